// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Instruction memory with a streaming load port; holds the mips
//            core in reset while a program is loaded, decodes HALT at fetch.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 1 << AW,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_start,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic          cpu_reset,
    output logic          loaded,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW + 1)'(1);
    localparam logic [4:0]  C_HALT  = 5'b11011;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_len;
    logic [AW:0]   w_len_sat;
    logic          r_loaded;
    logic          w_start;
    logic          w_accept;
    logic          w_last;
    logic [DW-1:0] r_mem [DEPTH];

    // A start is only honoured outside LOAD, so a start on the last word is dropped.
    always_comb begin
        w_len_sat = (ld_len > C_DEPTH) ? C_DEPTH : ld_len;
        w_start   = ld_start && ((r_state == IDLE) || (r_state == RUN));
        w_accept  = ld_valid && (r_state == LOAD);
        w_last    = w_accept && (r_cnt == (r_len - C_ONE));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RUN: begin
                if (ld_start) begin
                    w_state_nxt = (ld_len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (w_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_len    <= w_len_sat;
                r_cnt    <= '0;
                r_loaded <= (ld_len == '0);
            end else if (w_accept) begin
                r_cnt <= r_cnt + C_ONE;
                if (w_last) begin
                    r_loaded <= 1'b1;
                end
            end
        end
    end

    // Contents survive reset so a partially loaded image remains inspectable.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_cnt[AW-1:0]] <= ld_data;
        end
    end

    always_comb begin
        ld_ready  = (r_state == LOAD);
        cpu_reset = (r_state != RUN);
        loaded    = r_loaded;
        instr     = (r_state == RUN) ? r_mem[pc] : '0;
        halted    = (r_state == RUN) && (instr[15:11] == C_HALT);
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_start = 1'b0;
    logic [8:0]  ld_len = '0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready;
    logic [7:0]  pc = '0;
    logic [15:0] instr;
    logic        cpu_reset;
    logic        loaded;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] t1_words [3] = '{16'hA001, 16'hA102, 16'hA203};
    logic [15:0] t2_words [3] = '{16'hB001, 16'hB102, 16'hB203};
    logic [15:0] t4_words [3] = '{16'h1234, 16'h5678, 16'hD800};
    logic        vpat     [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    imem_loader #(.AW(8), .DEPTH(256), .DW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .pc        (pc),
        .instr     (instr),
        .cpu_reset (cpu_reset),
        .loaded    (loaded),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b want 0", ld_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (loaded !== 1'b0)    begin errors++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h want 0000", instr); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        int rdy = 0;
        ld_start = 1'b1; ld_len = 9'd3;
        tick();
        ld_start = 1'b0;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t1_load_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (loaded !== 1'b0)    begin errors++; $display("FAIL t1_load_loaded: got %b want 0", loaded); end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = t1_words[i];
            if (ld_ready === 1'b1) rdy++;
            tick();
        end
        ld_valid = 1'b0;
        checks++; if (rdy != 3) begin errors++; $display("FAIL t1_ready_cycles: got %0d want 3", rdy); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t1_flush_ready: got %b want 0", ld_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t1_flush_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (loaded !== 1'b1)    begin errors++; $display("FAIL t1_flush_loaded: got %b want 1", loaded); end
        tick();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL t1_run_cpu_reset: got %b want 0", cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i); #1;
            checks++; if (instr !== t1_words[i]) begin errors++; $display("FAIL t1_instr[%0d]: got %h want %h", i, instr, t1_words[i]); end
        end
    endtask

    task automatic test_gaps();
        int acc = 0;
        ld_start = 1'b1; ld_len = 9'd3;
        tick();
        ld_start = 1'b0;
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL t2_load_instr: got %h want 0000", instr); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t2_load_cpu_reset: got %b want 1", cpu_reset); end
        for (int j = 0; j < 6; j++) begin
            ld_valid = vpat[j];
            ld_data  = vpat[j] ? t2_words[acc] : 16'hEEEE;
            ld_start = (j == 2);
            ld_len   = (j == 2) ? 9'd1 : 9'd3;
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL t2_ready[%0d]: got %b want 1", j, ld_ready); end
            if (vpat[j]) acc++;
            tick();
        end
        ld_valid = 1'b0; ld_start = 1'b0;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL t2_flush_ready: got %b want 0", ld_ready); end
        checks++; if (loaded !== 1'b1)   begin errors++; $display("FAIL t2_flush_loaded: got %b want 1", loaded); end
        tick();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL t2_run_cpu_reset: got %b want 0", cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i); #1;
            checks++; if (instr !== t2_words[i]) begin errors++; $display("FAIL t2_instr[%0d]: got %h want %h", i, instr, t2_words[i]); end
        end
    endtask

    task automatic test_empty();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL t3_idle_loaded: got %b want 0", loaded); end
        ld_start = 1'b1; ld_len = 9'd0;
        tick();
        ld_start = 1'b0;
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t3_flush_ready: got %b want 0", ld_ready); end
        checks++; if (loaded !== 1'b1)    begin errors++; $display("FAIL t3_flush_loaded: got %b want 1", loaded); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t3_flush_cpu_reset: got %b want 1", cpu_reset); end
        tick();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL t3_run_cpu_reset: got %b want 0", cpu_reset); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t3_run_ready: got %b want 0", ld_ready); end
        pc = 8'd0; #1;
        checks++; if (instr !== 16'hB001) begin errors++; $display("FAIL t3_mem_kept: got %h want B001", instr); end
    endtask

    task automatic test_halt();
        ld_start = 1'b1; ld_len = 9'd3;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = t4_words[i];
            tick();
        end
        ld_valid = 1'b0;
        tick();
        pc = 8'd2; #1;
        checks++; if (halted !== 1'b1)    begin errors++; $display("FAIL t4_halted: got %b want 1", halted); end
        checks++; if (instr !== 16'hD800) begin errors++; $display("FAIL t4_instr_halt: got %h want D800", instr); end
        pc = 8'd0; #1;
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL t4_not_halted: got %b want 0", halted); end
        pc = 8'd2;
        ld_start = 1'b1; ld_len = 9'd1;
        tick();
        ld_start = 1'b0;
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL t4_reload_instr: got %h want 0000", instr); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t4_reload_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL t4_reload_halted: got %b want 0", halted); end
        checks++; if (ld_ready !== 1'b1)  begin errors++; $display("FAIL t4_reload_ready: got %b want 1", ld_ready); end
        ld_valid = 1'b1; ld_data = 16'h1111;
        tick();
        ld_valid = 1'b0;
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t4_one_word_ready: got %b want 0", ld_ready); end
        tick();
        pc = 8'd0; #1;
        checks++; if (instr !== 16'h1111) begin errors++; $display("FAIL t4_one_word_instr: got %h want 1111", instr); end
        pc = 8'd2; #1;
        checks++; if (instr !== 16'hD800) begin errors++; $display("FAIL t4_old_word_kept: got %h want D800", instr); end
        ld_start = 1'b1; ld_len = 9'd0;
        tick();
        ld_start = 1'b0;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t4_rerst_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (loaded !== 1'b1)    begin errors++; $display("FAIL t4_rerst_loaded: got %b want 1", loaded); end
        tick();
        pc = 8'd0; #1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL t4_rerst_run: got %b want 0", cpu_reset); end
        checks++; if (instr !== 16'h1111) begin errors++; $display("FAIL t4_rerst_instr: got %h want 1111", instr); end
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1; ld_len = 9'd4;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'hC0C0;
        tick();
        ld_data = 16'hC1C1;
        tick();
        ld_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t5_ready: got %b want 0", ld_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL t5_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (loaded !== 1'b0)    begin errors++; $display("FAIL t5_loaded: got %b want 0", loaded); end
        pc = 8'd0;  #0.1;
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL t5_instr_pc0: got %h want 0000", instr); end
        pc = 8'd5;  #0.1;
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL t5_instr_pc5: got %h want 0000", instr); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        ld_start = 1'b1; ld_len = 9'd0;
        tick();
        ld_start = 1'b0;
        tick();
        pc = 8'd0; #1;
        checks++; if (instr !== 16'hC0C0) begin errors++; $display("FAIL t5_partial0: got %h want C0C0", instr); end
        pc = 8'd1; #1;
        checks++; if (instr !== 16'hC1C1) begin errors++; $display("FAIL t5_partial1: got %h want C1C1", instr); end
        pc = 8'd2; #1;
        checks++; if (instr !== 16'hD800) begin errors++; $display("FAIL t5_untouched2: got %h want D800", instr); end
    endtask

    task automatic test_saturate();
        int acc = 0;
        ld_start = 1'b1; ld_len = 9'd300;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'(i) ^ 16'h5A00;
            if (ld_ready === 1'b1) acc++;
            tick();
        end
        ld_valid = 1'b0;
        checks++; if (acc != 256)         begin errors++; $display("FAIL t6_accepted: got %0d want 256", acc); end
        checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL t6_ready_after: got %b want 0", ld_ready); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL t6_run: got %b want 0", cpu_reset); end
        pc = 8'hFF; #1;
        checks++; if (instr !== 16'h5AFF) begin errors++; $display("FAIL t6_mem_ff: got %h want 5AFF", instr); end
        pc = 8'h00; #1;
        checks++; if (instr !== 16'h5A00) begin errors++; $display("FAIL t6_mem_00: got %h want 5A00", instr); end
        pc = 8'h80; #1;
        checks++; if (instr !== 16'h5A80) begin errors++; $display("FAIL t6_mem_80: got %h want 5A80", instr); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_empty();
        test_halt();
        test_reset_mid_load();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
